// File: rtl/jtframe_sdram_arb_pkg.sv
// jtframe_sdram_arb_pkg: shared FSM type, pointer width and round-robin grant search
package jtframe_sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} arb_state_t;
  localparam int MAX_SLOTS = 8;
  localparam int PW = $clog2(MAX_SLOTS);
  function automatic logic [PW:0] next_gnt(input logic [MAX_SLOTS-1:0] miss, input logic [PW-1:0] rr, input int slots);
    logic [PW:0] r;
    r = '0;
    for (int k = slots; k >= 1; k--) begin
      int idx;
      idx = (int'(rr) + k) % slots;
      if (miss[idx[PW-1:0]]) r = {1'b1, idx[PW-1:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/jtframe_sdram_arb_slot.sv
// jtframe_sdram_arb_slot: one-word read cache and hit flag for a single requester
module jtframe_sdram_arb_slot #(
  parameter int AW = 22,
  parameter int DW = 32
)(
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic          fill_valid,
  input  logic          inv,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic [DW-1:0] dout,
  output logic          ok,
  output logic          miss
);
  logic [AW-1:0] tag;
  logic          valid;
  logic          hit;
  assign hit  = valid & (tag == addr);
  assign miss = cs & ~hit;
  // cache line: invalidation wins over a fill, ok tracks the hit one cycle late
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) begin
      tag   <= '0;
      dout  <= '0;
      valid <= 1'b0;
      ok    <= 1'b0;
    end else begin
      ok    <= cs & hit & ~inv;
      tag   <= fill ? fill_addr : tag;
      dout  <= fill ? fill_data : dout;
      valid <= inv ? 1'b0 : fill ? fill_valid : valid;
    end
endmodule

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: round-robin sharing of the SDRAM read port among cached ROM slots
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
)(
  input  logic                clk_sys,
  input  logic                RESET,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic [SLOTS-1:0]    slot_ok,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en
);
  arb_state_t       state;
  logic [PW-1:0]    rr, gnt;
  logic             dl_seen;
  logic [SLOTS-1:0] miss;
  logic [PW:0]      nxt;
  logic [AW-1:0]    nxt_addr;
  logic             fill;
  assign nxt  = next_gnt(MAX_SLOTS'(miss), rr, SLOTS);
  assign fill = data_rdy & (state == WAIT_RDY | (state == WAIT_ACK & sdram_ack));
  // address of the slot that would be granted this cycle
  always_comb begin
    nxt_addr = '0;
    for (int i = 0; i < SLOTS; i++)
      if (nxt[PW-1:0] == PW'(i)) nxt_addr = slot_addr[i*AW +: AW];
  end
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    jtframe_sdram_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk_sys   (clk_sys),
      .RESET     (RESET),
      .cs        (slot_cs[i]),
      .addr      (slot_addr[i*AW +: AW]),
      .fill      (fill & (gnt == PW'(i))),
      .fill_valid(~(dl_seen | downloading)),
      .inv       (downloading),
      .fill_addr (sdram_addr),
      .fill_data (data_read),
      .dout      (slot_dout[i*DW +: DW]),
      .ok        (slot_ok[i]),
      .miss      (miss[i])
    );
  end
  // request FSM: grant, wait for acceptance, wait for data; a download never aborts it
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      rr         <= PW'(SLOTS-1);
      gnt        <= '0;
      dl_seen    <= 1'b0;
      refresh_en <= 1'b0;
    end else begin
      refresh_en <= state == IDLE & (~|miss | downloading);
      case (state)
        IDLE:
          if (~downloading & nxt[PW]) begin
            gnt        <= nxt[PW-1:0];
            rr         <= nxt[PW-1:0];
            sdram_addr <= nxt_addr;
            sdram_req  <= 1'b1;
            dl_seen    <= 1'b0;
            state      <= WAIT_ACK;
          end
        WAIT_ACK: begin
          dl_seen <= dl_seen | downloading;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= data_rdy ? IDLE : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          dl_seen <= dl_seen | downloading;
          state   <= data_rdy ? IDLE : WAIT_RDY;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb_jtframe_sdram_arb: directed checks of caching, round-robin, reset and download gating
module tb_jtframe_sdram_arb;
  localparam int SLOTS = 4;
  localparam int AW = 22;
  localparam int DW = 32;
  logic                clk_sys = 1'b0;
  logic                RESET = 1'b1;
  logic                downloading = 1'b0;
  logic [SLOTS-1:0]    slot_cs = '0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS*DW-1:0] slot_dout;
  logic [SLOTS-1:0]    slot_ok;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack = 1'b0;
  logic                data_rdy = 1'b0;
  logic [DW-1:0]       data_read = '0;
  logic                refresh_en;
  int tests = 0;
  int fails = 0;

  always #5 clk_sys = ~clk_sys;

  jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk_sys    (clk_sys),
    .RESET      (RESET),
    .downloading(downloading),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_dout  (slot_dout),
    .slot_ok    (slot_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read),
    .refresh_en (refresh_en)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_sys);
  endtask

  task automatic set_slot(input int i, input logic cs, input logic [AW-1:0] a);
    slot_cs[i] = cs;
    slot_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] dout_of(input int i);
    return slot_dout[i*DW +: DW];
  endfunction

  task automatic wait_req(input string tag, input logic [AW-1:0] a);
    int n;
    n = 0;
    while (!sdram_req && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_req"}, 64'(sdram_req), 64'd1);
    chk({tag, "_addr"}, 64'(sdram_addr), 64'(a));
  endtask

  task automatic serve(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_req(tag, a);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    data_rdy  = 1'b1;
    data_read = d;
    tick;
    data_rdy  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick;
    chk("rst_req", 64'(sdram_req), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_ok", 64'(slot_ok), 64'd0);
    chk("rst_refresh", 64'(refresh_en), 64'd0);
    chk("rst_dout", 64'(slot_dout[63:0]), 64'd0);
    RESET = 1'b0;
    tick;
    chk("idle_refresh", 64'(refresh_en), 64'd1);
    // single miss, then hits from the cache
    set_slot(0, 1'b1, AW'('h100));
    wait_req("miss0", AW'('h100));
    chk("busy_refresh", 64'(refresh_en), 64'd0);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    chk("ack_drop", 64'(sdram_req), 64'd0);
    data_rdy  = 1'b1;
    data_read = 32'hDEADBEEF;
    tick;
    data_rdy = 1'b0;
    chk("fill_lat", 64'(slot_ok[0]), 64'd0);
    tick;
    chk("miss0_ok", 64'(slot_ok[0]), 64'd1);
    chk("miss0_dout", 64'(dout_of(0)), 64'hDEADBEEF);
    set_slot(0, 1'b0, AW'('h100));
    tick;
    chk("cs_drop_ok", 64'(slot_ok[0]), 64'd0);
    set_slot(0, 1'b1, AW'('h100));
    tick;
    chk("rehit_ok", 64'(slot_ok[0]), 64'd1);
    chk("rehit_noreq", 64'(sdram_req), 64'd0);
    // address change while the transaction is outstanding
    set_slot(1, 1'b1, AW'('h200));
    wait_req("chg", AW'('h200));
    sdram_ack = 1'b1;
    set_slot(1, 1'b1, AW'('h204));
    tick;
    sdram_ack = 1'b0;
    data_rdy  = 1'b1;
    data_read = 32'h11112222;
    tick;
    data_rdy = 1'b0;
    tick;
    chk("chg_stale_ok", 64'(slot_ok[1]), 64'd0);
    chk("chg_stale_dout", 64'(dout_of(1)), 64'h11112222);
    serve("chg2", AW'('h204), 32'h22223333);
    tick;
    chk("chg2_ok", 64'(slot_ok[1]), 64'd1);
    chk("chg2_dout", 64'(dout_of(1)), 64'h22223333);
    // ack and data in the same cycle
    set_slot(2, 1'b1, AW'('h300));
    set_slot(3, 1'b1, AW'('h380));
    wait_req("ar", AW'('h300));
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'h33330000;
    tick;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    chk("ar_req_drop", 64'(sdram_req), 64'd0);
    tick;
    chk("ar_next_req", 64'(sdram_req), 64'd1);
    chk("ar_next_addr", 64'(sdram_addr), 64'h380);
    chk("ar_ok2", 64'(slot_ok[2]), 64'd1);
    chk("ar_dout2", 64'(dout_of(2)), 64'h33330000);
    serve("ar3", AW'('h380), 32'h38380000);
    tick;
    chk("all_ok", 64'(slot_ok), 64'hF);
    // reset in the middle of a transaction, then round-robin from a clean state
    set_slot(0, 1'b1, AW'('h150));
    wait_req("rstmid", AW'('h150));
    chk("rstmid_ok_pre", 64'(slot_ok), 64'hE);
    RESET = 1'b1;
    #1;
    chk("rstmid_req", 64'(sdram_req), 64'd0);
    chk("rstmid_ok", 64'(slot_ok), 64'd0);
    for (int i = 0; i < SLOTS; i++) set_slot(i, 1'b1, AW'('h10 + i));
    tick;
    RESET = 1'b0;
    for (int i = 0; i < SLOTS; i++) serve($sformatf("rr%0d", i), AW'('h10 + i), DW'('hA0 + i));
    tick;
    chk("rr_ok", 64'(slot_ok), 64'hF);
    for (int i = 0; i < SLOTS; i++) chk($sformatf("rr_dout%0d", i), 64'(dout_of(i)), 64'('hA0 + i));
    // invalidate slots 0 and 2 by moving their addresses
    set_slot(0, 1'b1, AW'('h20));
    set_slot(2, 1'b1, AW'('h22));
    serve("ri0", AW'('h20), 32'hB0);
    serve("ri2", AW'('h22), 32'hB2);
    tick;
    chk("ri_ok", 64'(slot_ok), 64'hF);
    chk("ri_dout0", 64'(dout_of(0)), 64'hB0);
    chk("ri_dout2", 64'(dout_of(2)), 64'hB2);
    // download starting while data is pending
    slot_cs = 4'b0010;
    set_slot(1, 1'b1, AW'('h40));
    wait_req("dl", AW'('h40));
    sdram_ack = 1'b1;
    tick;
    sdram_ack   = 1'b0;
    downloading = 1'b1;
    tick;
    data_rdy  = 1'b1;
    data_read = 32'hC0;
    tick;
    data_rdy = 1'b0;
    repeat (3) tick;
    chk("dl_noreq", 64'(sdram_req), 64'd0);
    chk("dl_ok", 64'(slot_ok), 64'd0);
    chk("dl_refresh", 64'(refresh_en), 64'd1);
    chk("dl_dout", 64'(dout_of(1)), 64'hC0);
    downloading = 1'b0;
    serve("dl_retry", AW'('h40), 32'hC1);
    tick;
    chk("dl_retry_ok", 64'(slot_ok[1]), 64'd1);
    chk("dl_retry_dout", 64'(dout_of(1)), 64'hC1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Multi-slot round-robin arbiter that shares the single game-side SDRAM read port (sdram_req/sdram_ack/data_rdy/data_read) among several ROM requesters: CPU, char, scroll and object fetchers.
- Each slot holds a one-word cache (tag, data, valid), so repeated reads of the same address complete without an SDRAM transaction.
- Sits inside the game top, between the per-subsystem ROM fetch logic and the frame SDRAM controller.
- Gates itself off during ROM download and signals when refresh may run.

Parameters:
- SLOTS, 4, number of requesters (2..8).
- AW, 22, SDRAM word address width.
- DW, 32, read data width.

Ports:
- clk_sys  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- downloading  in  1  ROM download in progress; blocks new requests.
- slot_cs  in  SLOTS  per-slot read request level.
- slot_addr  in  SLOTS*AW  per-slot address, slot i at [i*AW +: AW].
- slot_dout  out  SLOTS*DW  per-slot cached data.
- slot_ok  out  SLOTS  per-slot data valid for the current slot_addr.
- sdram_req  out  1  request to SDRAM controller.
- sdram_addr  out  AW  request address.
- sdram_ack  in  1  controller accepted the request, 1-cycle pulse.
- data_rdy  in  1  data_read valid, 1-cycle pulse.
- data_read  in  DW  SDRAM read data.
- refresh_en  out  1  high when the arbiter is idle with nothing pending.

Behaviour:
- All state is cleared asynchronously by RESET, which has priority over everything.
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, refresh_en=0, all valid=0, state=IDLE, rr pointer=SLOTS-1.
- Miss definition: slot i misses when slot_cs[i] & ~(valid[i] & tag[i]==slot_addr[i]).
- slot_ok register: each cycle, slot_ok[i] <= slot_cs[i] & valid[i] & (tag[i]==slot_addr[i]). Hit latency is 1 cycle after cs/addr are presented. slot_ok drops the cycle after cs falls or addr changes.
- FSM, states IDLE, WAIT_ACK, WAIT_RDY:
  - IDLE: if ~downloading and any slot misses, grant the first missing slot searching rr+1, rr+2, ... modulo SLOTS. Latch gnt index and address: sdram_addr <= slot_addr[gnt]. Set sdram_req <= 1 and rr <= gnt; go to WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack, sdram_req <= 0 and go to WAIT_RDY.
  - WAIT_RDY: on data_rdy, tag[gnt] <= latched address, data[gnt] <= data_read, valid[gnt] <= ~dl_seen; go to IDLE.
- Miss latency: slot_ok rises 1 cycle after the edge at which data_rdy is sampled, provided addr is unchanged.
- sdram_ack and data_rdy arriving in the same cycle while in WAIT_ACK are treated as ack+fill in one step: fill the cache and go straight to IDLE.
- Cache is keyed to the latched address. If the requester changes addr or drops cs mid-transaction, the transaction still completes and fills with the latched address. slot_ok then reflects the tag compare, and a new miss is arbitrated afterwards.
- Fairness: round-robin guarantees each missing slot is served within SLOTS transactions. A slot that stays hit never consumes a grant.
- downloading:
  - While high: no new grants, all valid bits cleared every cycle, slot_ok forced low next cycle.
  - An outstanding transaction is never aborted. dl_seen (set when downloading is high during the transaction) suppresses valid on fill.
- refresh_en <= (state==IDLE) & (no slot misses | downloading), registered.
- sdram_ack or data_rdy arriving in IDLE is ignored.

Decomposition:
- Package jtframe_sdram_arb_pkg:
  - state enum {IDLE, WAIT_ACK, WAIT_RDY}.
  - Localparam for the rr pointer width, $clog2(SLOTS).
  - Next-grant search function, SLOTS-generic.
- Sub-module jtframe_sdram_arb_slot, one instance per slot. It holds the tag/data/valid registers, the hit compare, the miss output and the slot_ok register, and takes fill/inv strobes from the FSM.

Test Plan:
- Reset mid-transaction: assert RESET in WAIT_ACK -> sdram_req=0, slot_ok=0 immediately. After release, a miss re-requests from IDLE.
- Single miss then hit:
  - slot0 cs=1, addr=0x00100 -> sdram_req with sdram_addr=0x00100. After ack and data_rdy with 0xDEADBEEF -> slot_ok[0]=1, slot_dout[0]=0xDEADBEEF one cycle later.
  - Re-present the same addr -> ok after 1 cycle with no sdram_req.
- Round-robin: all 4 slots miss at once with addrs 0x10..0x13 -> grant order 0,1,2,3. Re-invalidate slots 0 and 2 -> grant order 0,2 (rr resumes after the last grant).
- Address change mid-transaction: slot1 addr 0x200 granted, changed to 0x204 before data_rdy -> fill tag=0x200 with slot_ok[1]=0, then a second request for 0x204 -> ok.
- Download gating: downloading=1 during WAIT_RDY -> transaction completes, valid stays 0, no further sdram_req, refresh_en=1. Deassert downloading -> the pending miss re-requests.
- Simultaneous ack+data_rdy in WAIT_ACK -> cache filled, FSM returns to IDLE, next miss granted on the following cycle.
